// File: rtl/i2c_s_reg_target.sv
// I2C target that bridges controller write/read transactions onto an 8-bit register bus.
// Pad inputs are synchronized and glitch-filtered; the target never stretches SCL.
module i2c_s_reg_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h24,
    parameter int         FILT_LEN   = 2
) (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    localparam int CW = $clog2(FILT_LEN + 2);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, MACK
    } state_t;

    state_t          state;
    logic [1:0]      scl_p0, sda_p0;
    logic            scl_filt, sda_filt, scl_prev, sda_prev;
    logic [CW-1:0]   scl_cnt, sda_cnt;
    logic [2:0]      bit_cnt;
    logic [6:0]      shreg;
    logic [7:0]      tx;
    logic [7:0]      rx_byte;
    logic            byte_done, mack_ok, rw, rd_cap;
    logic            scl_rise, scl_fall, tx_drive, start_ev, stop_ev;

    // Stage p0: two-flop synchronizers, then a run-length filter per line
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            scl_p0   <= 2'b11;
            sda_p0   <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_p0   <= {scl_p0[0], scl_i};
            sda_p0   <= {sda_p0[0], sda_i};
            scl_prev <= scl_filt;
            sda_prev <= sda_filt;
            if (scl_p0[1] != scl_filt) begin
                if (scl_cnt == CW'(FILT_LEN)) begin
                    scl_filt <= scl_p0[1];
                    scl_cnt  <= '0;
                end else begin
                    scl_cnt <= scl_cnt + 1'b1;
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_p0[1] != sda_filt) begin
                if (sda_cnt == CW'(FILT_LEN)) begin
                    sda_filt <= sda_p0[1];
                    sda_cnt  <= '0;
                end else begin
                    sda_cnt <= sda_cnt + 1'b1;
                end
            end else begin
                sda_cnt <= '0;
            end
        end
    end

    // Bus events; SDA edges under a target-driven read bit cannot be START/STOP
    assign scl_rise = scl_filt & ~scl_prev;
    assign scl_fall = ~scl_filt & scl_prev;
    assign tx_drive = (state == RDATA) && sda_oe_o;
    assign start_ev = scl_filt & scl_prev & sda_prev & ~sda_filt & ~tx_drive;
    assign stop_ev  = scl_filt & scl_prev & ~sda_prev & sda_filt & ~tx_drive;
    assign rx_byte  = {shreg, sda_filt};

    // Stage p1: protocol FSM and register-bus strobes
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            mack_ok     <= 1'b0;
            rw          <= 1'b0;
            rd_cap      <= 1'b0;
            sda_oe_o    <= 1'b0;
            busy_o      <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
        end else begin
            reg_wr_o <= 1'b0;
            reg_rd_o <= 1'b0;
            rd_cap   <= reg_rd_o;
            if (rd_cap)
                tx <= reg_rdata_i;
            if (reg_wr_o)
                reg_addr_o <= reg_addr_o + 8'd1;

            if (stop_ev) begin
                state     <= IDLE;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b0;
                byte_done <= 1'b0;
                mack_ok   <= 1'b0;
            end else if (start_ev) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b0;
                byte_done <= 1'b0;
                mack_ok   <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                                        byte_done <= 1'b1;
                                        rw        <= rx_byte[0];
                                    end else begin
                                        state <= IDLE;
                                    end
                                end else if (state == PTR) begin
                                    reg_addr_o <= rx_byte;
                                    byte_done  <= 1'b1;
                                end else begin
                                    reg_wdata_o <= rx_byte;
                                    reg_wr_o    <= 1'b1;
                                    byte_done   <= 1'b1;
                                end
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe_o  <= 1'b1;
                            busy_o    <= 1'b1;
                            if (state == ADDR) begin
                                state    <= ACK_ADDR;
                                reg_rd_o <= rw;
                            end else if (state == PTR) begin
                                state <= ACK_PTR;
                            end else begin
                                state <= ACK_WDATA;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                state    <= RDATA;
                                sda_oe_o <= ~tx[7];
                                tx       <= {tx[6:0], 1'b0};
                            end else begin
                                state    <= PTR;
                                sda_oe_o <= 1'b0;
                            end
                        end
                    end
                    ACK_PTR, ACK_WDATA: begin
                        if (scl_fall) begin
                            state    <= WDATA;
                            bit_cnt  <= '0;
                            sda_oe_o <= 1'b0;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                state      <= MACK;
                                sda_oe_o   <= 1'b0;
                                reg_addr_o <= reg_addr_o + 8'd1;
                            end else begin
                                sda_oe_o <= ~tx[7];
                                tx       <= {tx[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            if (!sda_filt) begin
                                reg_rd_o <= 1'b1;
                                mack_ok  <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end else if (scl_fall && mack_ok) begin
                            mack_ok  <= 1'b0;
                            state    <= RDATA;
                            bit_cnt  <= '0;
                            sda_oe_o <= ~tx[7];
                            tx       <= {tx[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_s_reg_target.sv
// Bench for i2c_s_reg_target: a bit-banged I2C controller, a register-file device on the
// register bus, table-driven write vectors, directed corner cases and randomized transactions.
module tb_i2c_s_reg_target;

    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, busy;

    logic [7:0]  regs [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          oe_cnt = 0;

    logic [7:0]  exp_mem [256];
    logic [7:0]  mptr;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [7:0]       addr_byte;
        logic [7:0]       ptr;
        int               nd;
        logic [2:0][7:0]  d;
        int               exp_acks;
        logic [7:0]       exp_ptr;
    } wvec_t;

    wvec_t vecs [4];

    always #5 clk = ~clk;

    assign sda_bus   = sda_m & ~sda_oe;
    assign reg_rdata = regs[reg_addr];

    i2c_s_reg_target dut (
        .sys_clk_i   (clk),
        .rst_i       (rst),
        .scl_i       (scl),
        .sda_i       (sda_bus),
        .sda_oe_o    (sda_oe),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_wr_o    (reg_wr),
        .reg_rd_o    (reg_rd),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy)
    );

    // Register-file device and bus monitor
    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'(i + 8'h80);
        forever begin
            @(negedge clk);
            if (reg_wr) begin
                regs[reg_addr] = reg_wdata;
                wr_q.push_back({reg_addr, reg_wdata});
            end
            if (reg_rd) rd_q.push_back(reg_addr);
            if (sda_oe) oe_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_cyc(Q);
        scl = 1'b1;   wait_cyc(2 * Q);
        sda_m = 1'b0; wait_cyc(2 * Q);
        scl = 1'b0;   wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(Q);
        scl = 1'b1;   wait_cyc(2 * Q);
        sda_m = 1'b1; wait_cyc(2 * Q);
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        sda_m = v;
        if (glitch) begin
            wait_cyc(4);
            scl = 1'b1; wait_cyc(2);
            scl = 1'b0; wait_cyc(Q - 6);
        end else begin
            wait_cyc(Q);
        end
        scl = 1'b1; wait_cyc(2 * Q);
        scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == gbit);
        sda_m = 1'b1; wait_cyc(Q);
        scl = 1'b1;   wait_cyc(Q);
        ack = ~sda_bus;
        wait_cyc(Q);
        scl = 1'b0;   wait_cyc(Q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; wait_cyc(Q);
            scl = 1'b1;   wait_cyc(Q);
            b = {b[6:0], sda_bus};
            wait_cyc(Q);
            scl = 1'b0;   wait_cyc(Q);
        end
        sda_m = ~mack; wait_cyc(Q);
        scl = 1'b1;    wait_cyc(2 * Q);
        scl = 1'b0;    wait_cyc(Q);
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int nd,
                            input logic [2:0][7:0] d, input int gbit, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        write_byte(ab, -1, a); acks += int'(a);
        write_byte(p, -1, a);  acks += int'(a);
        for (int i = 0; i < nd; i++) begin
            write_byte(d[i], (i == 0) ? gbit : -1, a);
            acks += int'(a);
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [7:0] p, input int nd, output logic [2:0][7:0] got);
        logic a;
        got = '0;
        i2c_start();
        write_byte(8'h48, -1, a); chk("rd_addrw_ack", a, 1'b1);
        write_byte(p, -1, a);     chk("rd_ptr_ack", a, 1'b1);
        i2c_start();
        write_byte(8'h49, -1, a); chk("rd_addrr_ack", a, 1'b1);
        chk("rd_busy", busy, 1'b1);
        for (int i = 0; i < nd; i++) read_byte(i != nd - 1, got[i]);
        chk("busy_after_nack", busy, 1'b0);
        i2c_stop();
    endtask

    // Compare new write strobes against the expected (addr, data) sequence
    task automatic chk_writes(input int base, input logic [7:0] p, input int n,
                              input logic [2:0][7:0] d);
        chk("wr_count", wr_q.size() - base, n);
        for (int i = 0; i < n && base + i < wr_q.size(); i++) begin
            chk("wr_addr", wr_q[base + i][15:8], 8'(p + i));
            chk("wr_data", wr_q[base + i][7:0], d[i]);
        end
    endtask

    initial begin
        int              acks, wb, rb, oe0, nd;
        logic            a;
        logic [7:0]      p, ab;
        logic [2:0][7:0] d, got;

        vecs[0] = '{8'h48, 8'h10, 2, {8'h00, 8'h5A, 8'hA5}, 4, 8'h12};
        vecs[1] = '{8'h48, 8'hFF, 2, {8'h00, 8'h02, 8'h01}, 4, 8'h01};
        vecs[2] = '{8'hA0, 8'h33, 1, {8'h00, 8'h00, 8'h99}, 0, 8'h01};
        vecs[3] = '{8'h48, 8'h7F, 1, {8'h00, 8'h00, 8'h80}, 3, 8'h80};

        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i + 8'h80);
        mptr = 8'h00;

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        wait_cyc(3);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        chk("rst_reg_wr", reg_wr, 1'b0);
        chk("rst_reg_rd", reg_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_cyc(10);

        // Table-driven write transactions
        for (int v = 0; v < 4; v++) begin
            wb  = wr_q.size();
            rb  = rd_q.size();
            oe0 = oe_cnt;
            do_write(vecs[v].addr_byte, vecs[v].ptr, vecs[v].nd, vecs[v].d, -1, acks);
            chk("vec_acks", acks, vecs[v].exp_acks);
            chk("vec_ptr", reg_addr, vecs[v].exp_ptr);
            chk("vec_busy_idle", busy, 1'b0);
            chk("vec_no_rd", rd_q.size() - rb, 0);
            chk("vec_oe_activity", oe_cnt != oe0, vecs[v].exp_acks != 0);
            if (vecs[v].exp_acks != 0) begin
                chk_writes(wb, vecs[v].ptr, vecs[v].nd, vecs[v].d);
                for (int i = 0; i < vecs[v].nd; i++)
                    exp_mem[8'(vecs[v].ptr + i)] = vecs[v].d[i];
                mptr = vecs[v].exp_ptr;
            end else begin
                chk_writes(wb, vecs[v].ptr, 0, vecs[v].d);
            end
        end

        // Pointer write then repeated-START read of two bytes
        rb = rd_q.size();
        do_read(8'h20, 2, got);
        chk("rd_byte0", got[0], 8'hA0);
        chk("rd_byte1", got[1], 8'hA1);
        chk("rd_strobes", rd_q.size() - rb, 2);
        if (rd_q.size() - rb == 2) begin
            chk("rd_addr0", rd_q[rb], 8'h20);
            chk("rd_addr1", rd_q[rb + 1], 8'h21);
        end
        chk("rd_ptr_after", reg_addr, 8'h22);
        mptr = 8'h22;

        // SCL glitch inside a data bit must not add a sampled bit
        wb = wr_q.size();
        d  = {8'h00, 8'h00, 8'h3C};
        do_write(8'h48, 8'h30, 1, d, 2, acks);
        chk("glitch_acks", acks, 3);
        chk_writes(wb, 8'h30, 1, d);
        exp_mem[8'h30] = 8'h3C;

        // START after three bits of a data byte drops the partial byte
        wb = wr_q.size();
        i2c_start();
        write_byte(8'h48, -1, a);
        write_byte(8'h40, -1, a);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        i2c_start();
        chk("restart_no_wr", wr_q.size() - wb, 0);
        chk("restart_busy", busy, 1'b0);
        write_byte(8'h48, -1, a); chk("restart_addr_ack", a, 1'b1);
        write_byte(8'h44, -1, a); chk("restart_ptr_ack", a, 1'b1);
        write_byte(8'h77, -1, a); chk("restart_data_ack", a, 1'b1);
        i2c_stop();
        d = {8'h00, 8'h00, 8'h77};
        chk_writes(wb, 8'h44, 1, d);
        chk("restart_ptr", reg_addr, 8'h45);
        exp_mem[8'h44] = 8'h77;

        // Reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(a ? 1'b0 : 1'b0, 1'b0) ;
        sda_m = 1'b1;
        for (int i = 0; i < 60 && !sda_oe; i++) wait_cyc(1);
        chk("rst_mid_ack_seen", sda_oe, 1'b0);
        i2c_stop();
        wait_cyc(4 * Q);
        i2c_start();
        p = 8'h48;
        for (int i = 7; i >= 0; i--) send_bit(p[i], 1'b0);
        sda_m = 1'b1;
        for (int i = 0; i < 60 && !sda_oe; i++) wait_cyc(1);
        chk("rst_mid_ack_drive", sda_oe, 1'b1);
        rst = 1'b1;
        wait_cyc(1);
        chk("rst_mid_ack_oe", sda_oe, 1'b0);
        chk("rst_mid_ack_ptr", reg_addr, 8'h00);
        chk("rst_mid_ack_busy", busy, 1'b0);
        rst = 1'b0;
        wait_cyc(Q);
        scl = 1'b1; sda_m = 1'b1;
        wait_cyc(4 * Q);
        wb = wr_q.size();
        d  = {8'h00, 8'h00, 8'hC3};
        do_write(8'h48, 8'h55, 1, d, -1, acks);
        chk("post_rst_acks", acks, 3);
        chk_writes(wb, 8'h55, 1, d);
        chk("post_rst_ptr", reg_addr, 8'h56);
        exp_mem[8'h55] = 8'hC3;
        mptr = 8'h56;

        // Randomized transactions against the register-file model
        for (int t = 0; t < 12; t++) begin
            nd = $urandom_range(1, 3);
            p  = 8'($urandom);
            for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
            wb = wr_q.size();
            rb = rd_q.size();
            if ($urandom_range(0, 2) != 2) begin
                if ($urandom_range(0, 4) != 0) begin
                    ab = 8'h48;
                end else begin
                    ab = {7'($urandom_range(0, 127)), 1'b0};
                    if (ab[7:1] == 7'h24) ab = 8'h4A;
                end
                do_write(ab, p, nd, d, -1, acks);
                if (ab == 8'h48) begin
                    chk("rnd_w_acks", acks, nd + 2);
                    chk_writes(wb, p, nd, d);
                    for (int i = 0; i < nd; i++) exp_mem[8'(p + i)] = d[i];
                    mptr = 8'(p + nd);
                end else begin
                    chk("rnd_w_nack", acks, 0);
                    chk_writes(wb, p, 0, d);
                end
            end else begin
                do_read(p, nd, got);
                for (int i = 0; i < nd; i++) chk("rnd_r_data", got[i], exp_mem[8'(p + i)]);
                chk("rnd_r_strobes", rd_q.size() - rb, nd);
                for (int i = 0; i < nd && rb + i < rd_q.size(); i++)
                    chk("rnd_r_addr", rd_q[rb + i], 8'(p + i));
                chk("rnd_r_no_wr", wr_q.size() - wb, 0);
                mptr = 8'(p + nd);
            end
            chk("rnd_ptr", reg_addr, mptr);
            chk("rnd_busy_idle", busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_s_reg_target.md
# i2c_s_reg_target

I2C target (slave) that responds to write and read transactions from an I2C controller and converts them into a simple 8-bit register bus. It is the responder end of the byte-oriented controller write sequencing used for sensor configuration. It lets the SoC expose on-chip configuration/status registers to an external I2C controller, and it serves as the bench partner for the controller block. It never stretches SCL.

## Interface
- SLAVE_ADDR, 7'h24, 7-bit target address matched against the first byte after START
- FILT_LEN, 2, glitch-filter depth in sys_clk cycles (27 MHz: 1 cycle ≈ 37 ns)

- sys_clk_i  in  1  system clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- scl_i  in  1  raw SCL from pad, asynchronous
- sda_i  in  1  raw SDA from pad, asynchronous
- sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release
- reg_addr_o  out  8  register pointer
- reg_wdata_o  out  8  write data; valid while reg_wr_o=1
- reg_wr_o  out  1  one-cycle write strobe
- reg_rd_o  out  1  one-cycle read strobe for reg_addr_o
- reg_rdata_i  in  8  read data; must be valid the cycle after reg_rd_o
- busy_o  out  1  high while this target is addressed

## Operation
- Conditioning: each line uses a 2-flop synchronizer. The filtered value updates only after FILT_LEN+1 consecutive equal synchronized samples. On reset, the filtered values are forced to 1.
- Events, all from filtered signals:
  - START: SDA 1→0 while SCL=1
  - STOP: SDA 0→1 while SCL=1
  - scl_rise / scl_fall: SCL edges
- Bit transfer: receive bits are sampled on scl_rise, MSB first. Transmit bits change on scl_fall. A 3-bit counter tracks bits 0..7.
- States: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, MACK.
- IDLE: ignores everything except START.
- START, in any state (including repeated start): go to ADDR, clear the bit counter, set sda_oe_o=0, busy_o=0.
- STOP, in any state: go to IDLE, set sda_oe_o=0, busy_o=0. The pointer is retained.
- ADDR, after the 8th bit:
  - byte[7:1]==SLAVE_ADDR: on the next scl_fall drive the ACK (sda_oe_o=1) and set busy_o=1. If R/W=0, go to ACK_ADDR→PTR. If R/W=1, go to ACK_ADDR→RDATA.
  - Mismatch: no ACK; go to IDLE.
- ACK states: the ACK is released on the scl_fall that ends the ACK clock.
- Write path:
  - First byte after the address: loaded into the pointer (PTR, ACK_PTR).
  - Each later byte (WDATA): reg_wdata_o=byte, reg_wr_o pulses at reg_addr_o, then the target ACKs.
  - The pointer increments in the cycle after the strobe, wrapping 0xFF→0x00.
  - Writes are always ACKed.
- Read path:
  - reg_rd_o pulses on entry to ACK_ADDR. reg_rdata_i is captured into the TX shift register the next cycle.
  - On the scl_fall ending the ACK, drive MSB: sda_oe_o = ~bit. Each scl_fall shifts the next bit out.
  - After bit 0, the next scl_fall releases SDA and the state becomes MACK. The pointer increments (wrapping) when the 8th bit is shifted out.
  - MACK, on scl_rise: SDA=0 (ACK) → pulse reg_rd_o at the new pointer, capture, then return to RDATA; first bit on the next scl_fall. SDA=1 (NACK) → go to IDLE with SDA released.
- Arithmetic: the pointer is 8-bit modulo-256.
- Boundary cases:
  - START mid-byte discards the partial byte; no reg_wr_o is issued.
  - STOP during an ACK releases SDA in the same cycle as the STOP.
  - STOP mid-read-byte releases SDA immediately.
  - SDA edges while SCL=1 that occur during a target-driven bit are ignored. Such edges cannot originate from the target, because the target changes SDA only on scl_fall.

## Timing
- Reset values: sda_oe_o=0, reg_addr_o=0x00, reg_wdata_o=0x00, reg_wr_o=0, reg_rd_o=0, busy_o=0, state IDLE.
- Input latency from pad to event: 2 + FILT_LEN + 1 cycles (5 with the default). Edges on SDA and SCL see equal latency, so START/STOP ordering is preserved.
- Minimum sys_clk: ≥ 8 × (sync+filter latency) × SCL frequency. 27 MHz supports 400 kHz.
- sda_oe_o changes exactly 1 cycle after the scl_fall detection.
- reg_wr_o is asserted 1 cycle after the 8th-bit scl_rise detection. It is high for exactly 1 cycle. The pointer updates 1 cycle later.
- reg_rd_o is high for 1 cycle. The TX register loads on the following cycle, well before the next scl_fall.
- Pulses below FILT_LEN+1 cycles on either line produce no event.

## Test plan
- Write 0x48, ptr 0x10, data 0xA5, 0x5A, STOP → 4 ACKs, reg_wr_o at 0x10=0xA5 then 0x11=0x5A, reg_addr_o=0x12 after.
- Write ptr 0xFF, data 0x01, 0x02 → writes at 0xFF then 0x00 (wrap), ACKed.
- Write ptr 0x20, repeated START, read 0x49, master ACK then NACK, rdata = addr+0x80 → bytes 0xA0, 0xA1 on SDA, reg_rd_o at 0x20, 0x21, IDLE after NACK.
- Address 0x50 (mismatch) → no ACK, sda_oe_o stays 0, no strobes, busy_o=0.
- 2-cycle glitch on SCL during data bit, and START after 3 bits of data byte → no extra bit sampled; partial byte dropped, no reg_wr_o, ADDR state.
- rst_i asserted mid-ACK (sda_oe_o=1) → next cycle sda_oe_o=0, pointer 0x00, busy_o=0; subsequent full write transaction succeeds.
